// File: rtl/imm_gen_pkg.sv
// Shared definitions for the immediate generator: select-code width and
// the immediate-type encodings used by the decode stage.
package imm_gen_pkg;

    localparam int IMM_SEL_W = 3;

    typedef logic [IMM_SEL_W-1:0] imm_sel_t;

    localparam imm_sel_t IMM_I = 3'b000;
    localparam imm_sel_t IMM_S = 3'b001;
    localparam imm_sel_t IMM_B = 3'b010;
    localparam imm_sel_t IMM_J = 3'b011;
    localparam imm_sel_t IMM_U = 3'b100;
    localparam imm_sel_t IMM_Z = 3'b101;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Request/response bundle between decode and the immediate generator,
// including the illegal-select counter and its clear.
interface imm_gen_pipe_if #(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 8,
    parameter int ERR_CNT_W = 8
) ();
    import imm_gen_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [31:7]          in_instr;
    imm_sel_t             in_immsrc;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_immext;
    logic [TAG_W-1:0]     out_tag;
    logic                 out_illegal;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 err_clr;

    modport master (
        output in_valid, in_instr, in_immsrc, in_tag, out_ready, err_clr,
        input  in_ready, out_valid, out_immext, out_tag, out_illegal, err_cnt
    );

    modport slave (
        input  in_valid, in_instr, in_immsrc, in_tag, out_ready, err_clr,
        output in_ready, out_valid, out_immext, out_tag, out_illegal, err_cnt
    );

endinterface

// File: rtl/imm_gen_comb.sv
// Pure combinational immediate extraction and sign extension.
// Optional feature: IMM_GEN_ZICSR_EN makes select 101 a legal Z-type (CSR uimm).
module imm_gen_comb
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr_i,
    input  imm_sel_t        immsrc_i,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    logic [31:0] imm32_s;

    // Assemble the 32-bit immediate for the selected format, then replicate bit 31 upward.
    always_comb begin
        imm32_s   = 32'd0;
        illegal_o = 1'b0;
        case (immsrc_i)
            IMM_I: imm32_s = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm32_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm32_s = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
            IMM_J: imm32_s = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
            IMM_U: imm32_s = {instr_i[31:12], 12'd0};
`ifdef IMM_GEN_ZICSR_EN
            // Zero-extended uimm: bit 31 is 0 so the upward replication stays zero.
            IMM_Z: imm32_s = {27'd0, instr_i[19:15]};
`endif
            default: begin
                imm32_s   = 32'd0;
                illegal_o = 1'b1;
            end
        endcase
        imm_o       = {XLEN{imm32_s[31]}};
        imm_o[31:0] = imm32_s;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a one-entry skid buffer: one result
// per cycle, one-cycle latency, in_ready driven only from the skid flag.
// Optional feature: IMM_GEN_ZICSR_EN (see imm_gen_comb) enables Z-type select 101.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 8,
    parameter int ERR_CNT_W = 8
) (
    input logic           clk,
    input logic           rst_n,
    imm_gen_pipe_if.slave bus
);

    logic [XLEN-1:0]      in_imm_s;
    logic                 in_ill_s;
    logic                 accept_s;
    logic                 out_load_s;

    logic                 out_vld_q,  out_vld_d;
    logic [XLEN-1:0]      out_imm_q,  out_imm_d;
    logic [TAG_W-1:0]     out_tag_q,  out_tag_d;
    logic                 out_ill_q,  out_ill_d;
    logic                 skid_vld_q, skid_vld_d;
    logic [XLEN-1:0]      skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0]     skid_tag_q, skid_tag_d;
    logic                 skid_ill_q, skid_ill_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;

    imm_gen_comb #(.XLEN(XLEN)) u_comb (
        .instr_i   (bus.in_instr),
        .immsrc_i  (bus.in_immsrc),
        .imm_o     (in_imm_s),
        .illegal_o (in_ill_s)
    );

    // Next-state for the output register, skid entry and illegal counter.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_imm_d  = out_imm_q;
        out_tag_d  = out_tag_q;
        out_ill_d  = out_ill_q;
        skid_vld_d = skid_vld_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        skid_ill_d = skid_ill_q;
        err_cnt_d  = err_cnt_q;

        accept_s   = bus.in_valid & ~skid_vld_q;
        out_load_s = ~out_vld_q | bus.out_ready;

        if (out_load_s) begin
            if (skid_vld_q) begin
                // Older entry waiting in the skid goes first to keep FIFO order.
                out_vld_d  = 1'b1;
                out_imm_d  = skid_imm_q;
                out_tag_d  = skid_tag_q;
                out_ill_d  = skid_ill_q;
                skid_vld_d = 1'b0;
            end else if (accept_s) begin
                out_vld_d = 1'b1;
                out_imm_d = in_imm_s;
                out_tag_d = bus.in_tag;
                out_ill_d = in_ill_s;
            end else begin
                out_vld_d = 1'b0;
            end
        end else begin
            if (accept_s) begin
                // Output is stalled: park the new request in the skid entry.
                skid_vld_d = 1'b1;
                skid_imm_d = in_imm_s;
                skid_tag_d = bus.in_tag;
                skid_ill_d = in_ill_s;
            end else begin
                skid_vld_d = skid_vld_q;
            end
        end

        if (bus.err_clr) begin
            err_cnt_d = {ERR_CNT_W{1'b0}};
        end else if (accept_s && in_ill_s && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State registers; asynchronous reset discards any in-flight results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_imm_q  <= {XLEN{1'b0}};
            out_tag_q  <= {TAG_W{1'b0}};
            out_ill_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            skid_imm_q <= {XLEN{1'b0}};
            skid_tag_q <= {TAG_W{1'b0}};
            skid_ill_q <= 1'b0;
            err_cnt_q  <= {ERR_CNT_W{1'b0}};
        end else begin
            out_vld_q  <= out_vld_d;
            out_imm_q  <= out_imm_d;
            out_tag_q  <= out_tag_d;
            out_ill_q  <= out_ill_d;
            skid_vld_q <= skid_vld_d;
            skid_imm_q <= skid_imm_d;
            skid_tag_q <= skid_tag_d;
            skid_ill_q <= skid_ill_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.in_ready    = ~skid_vld_q;
    assign bus.out_valid   = out_vld_q;
    assign bus.out_immext  = out_imm_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.out_illegal = out_ill_q;
    assign bus.err_cnt     = err_cnt_q;

endmodule
